// File: rtl/shared_ivc_bank_controller.sv
// -----------------------------------------------------------------------------
// shared_ivc_bank_controller
//
// Hands the free shared VCs of one shared VC bank to head-flit requests from
// the port that currently owns the bank. It tracks per-VC ownership and flit
// occupancy. It reports the ownership map and the empty/full flags back to the
// bank allocator, which uses them to decide when bank ownership may move.
//
// Ports:
//   clk_i                        clock
//   reset_i                      synchronous active-high reset
//   memory_bank_grant_i          one-hot port owning this bank (from allocator)
//   ready_for_allocation_i       1 = new shared-VC grants permitted
//   alloc_req_i                  per-port request for a shared VC
//   alloc_gnt_o                  registered one-hot port grant, 1-cycle pulse
//   alloc_gnt_vc_o               registered one-hot VC granted, valid with alloc_gnt_o
//   flit_write_i                 flit enqueued into shared VC v
//   flit_read_i                  flit dequeued from shared VC v
//   flit_tail_i                  dequeued flit is a tail (qualified by flit_read_i)
//   allocated_ip_shared_ivc_o    bit p*num_vcs_per_bank+v = VC v held by port p
//   shared_ivc_empty_o           occupancy of VC v == 0
//   shared_ivc_full_o            occupancy of VC v == buffer_depth
//   error_o                      sticky protocol-violation flag
// -----------------------------------------------------------------------------
module shared_ivc_bank_controller #(
    parameter int num_ports        = 5,
    parameter int num_vcs_per_bank = 2,
    parameter int buffer_depth     = 4,
    parameter int occ_width        = 3
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_ports-1:0]                  memory_bank_grant_i,
    input  logic                                  ready_for_allocation_i,
    input  logic [num_ports-1:0]                  alloc_req_i,
    output logic [num_ports-1:0]                  alloc_gnt_o,
    output logic [num_vcs_per_bank-1:0]           alloc_gnt_vc_o,
    input  logic [num_vcs_per_bank-1:0]           flit_write_i,
    input  logic [num_vcs_per_bank-1:0]           flit_read_i,
    input  logic [num_vcs_per_bank-1:0]           flit_tail_i,
    output logic [num_ports*num_vcs_per_bank-1:0] allocated_ip_shared_ivc_o,
    output logic [num_vcs_per_bank-1:0]           shared_ivc_empty_o,
    output logic [num_vcs_per_bank-1:0]           shared_ivc_full_o,
    output logic                                  error_o
);

    localparam int NV = num_vcs_per_bank;
    localparam int NP = num_ports;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int VW = (NV > 1) ? $clog2(NV) : 1;

    localparam logic [occ_width-1:0] DEPTH_C = occ_width'(buffer_depth);
    localparam logic [occ_width-1:0] ZERO_C  = '0;
    localparam logic [occ_width-1:0] ONE_C   = occ_width'(1);

    // Per-VC state encoding
    localparam logic ST_FREE  = 1'b0;
    localparam logic ST_ALLOC = 1'b1;

    // One-hot encode a port index
    function automatic logic [NP-1:0] port_onehot(input logic [PW-1:0] idx);
        logic [NP-1:0] r;
        r = '0;
        for (int p = 0; p < NP; p++) begin
            if (idx == PW'(p)) begin
                r[p] = 1'b1;
            end else begin
                r[p] = 1'b0;
            end
        end
        return r;
    endfunction

    // One-hot encode a VC index
    function automatic logic [NV-1:0] vc_onehot(input logic [VW-1:0] idx);
        logic [NV-1:0] r;
        r = '0;
        for (int v = 0; v < NV; v++) begin
            if (idx == VW'(v)) begin
                r[v] = 1'b1;
            end else begin
                r[v] = 1'b0;
            end
        end
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [NV-1:0]                state_q, state_d;
    logic [NV-1:0][PW-1:0]        owner_q, owner_d;
    logic [NV-1:0][occ_width-1:0] occ_q, occ_d;
    logic [VW-1:0]                rr_q, rr_d;
    logic [NP-1:0]                alloc_gnt_q, alloc_gnt_d;
    logic [NV-1:0]                alloc_gnt_vc_q, alloc_gnt_vc_d;
    logic                         error_q, error_d;

    // Combinational helpers
    logic [PW-1:0] owner_idx_s;
    logic          owner_valid_s;
    logic          multi_hot_s;
    logic          owner_req_s;
    logic          sel_found_s;
    logic [VW-1:0] sel_vc_s;
    logic          grant_s;
    logic [NV-1:0] rd_ok_s;
    logic [NV-1:0] wr_ok_s;
    logic          flit_err_s;

    // Lowest set bit of the bank grant selects the owning port
    always_comb begin
        owner_idx_s   = '0;
        owner_valid_s = 1'b0;
        for (int p = NP - 1; p >= 0; p--) begin
            if (memory_bank_grant_i[p]) begin
                owner_idx_s   = PW'(p);
                owner_valid_s = 1'b1;
            end else begin
                owner_valid_s = owner_valid_s;
            end
        end
        // x & (x-1) clears the lowest set bit; anything left means multi-hot
        multi_hot_s = ((memory_bank_grant_i & (memory_bank_grant_i - NP'(1))) != '0);
        owner_req_s = alloc_req_i[owner_idx_s];
    end

    // Round-robin search for a FREE VC starting at the pointer
    always_comb begin
        sel_found_s = 1'b0;
        sel_vc_s    = '0;
        for (int k = 0; k < NV; k++) begin
            if (!sel_found_s && (state_q[(int'(rr_q) + k) % NV] == ST_FREE)) begin
                sel_found_s = 1'b1;
                sel_vc_s    = VW'((int'(rr_q) + k) % NV);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        grant_s = ready_for_allocation_i & owner_valid_s & owner_req_s & sel_found_s;
    end

    // Grant outputs and pointer advance
    always_comb begin
        if (grant_s) begin
            alloc_gnt_d    = port_onehot(owner_idx_s);
            alloc_gnt_vc_d = vc_onehot(sel_vc_s);
            if (sel_vc_s == VW'(NV - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = sel_vc_s + VW'(1);
            end
        end else begin
            alloc_gnt_d    = '0;
            alloc_gnt_vc_d = '0;
            rr_d           = rr_q;
        end
    end

    // Per-VC occupancy, state and owner update
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        occ_d      = occ_q;
        rd_ok_s    = '0;
        wr_ok_s    = '0;
        flit_err_s = 1'b0;
        for (int v = 0; v < NV; v++) begin
            // A read on an empty VC is dropped; a write on a full VC is
            // dropped unless a read frees a slot in the same cycle.
            rd_ok_s[v] = flit_read_i[v] && (occ_q[v] != ZERO_C);
            wr_ok_s[v] = flit_write_i[v] && ((occ_q[v] != DEPTH_C) || rd_ok_s[v]);

            if ((flit_read_i[v] && !rd_ok_s[v]) ||
                (flit_write_i[v] && !wr_ok_s[v]) ||
                (flit_write_i[v] && (state_q[v] == ST_FREE))) begin
                flit_err_s = 1'b1;
            end else begin
                flit_err_s = flit_err_s;
            end

            if (wr_ok_s[v] && !rd_ok_s[v]) begin
                occ_d[v] = occ_q[v] + ONE_C;
            end else if (rd_ok_s[v] && !wr_ok_s[v]) begin
                occ_d[v] = occ_q[v] - ONE_C;
            end else begin
                occ_d[v] = occ_q[v];
            end

            // A tail only releases the VC once its buffer is empty after the read
            if (rd_ok_s[v] && flit_tail_i[v]) begin
                if (occ_d[v] == ZERO_C) begin
                    state_d[v] = ST_FREE;
                end else begin
                    flit_err_s = 1'b1;
                end
            end else begin
                state_d[v] = state_d[v];
            end

            if (grant_s && (sel_vc_s == VW'(v))) begin
                state_d[v] = ST_ALLOC;
                owner_d[v] = owner_idx_s;
            end else begin
                owner_d[v] = owner_d[v];
            end
        end
        error_d = error_q | multi_hot_s | flit_err_s;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= '0;
            owner_q        <= '0;
            occ_q          <= '0;
            rr_q           <= '0;
            alloc_gnt_q    <= '0;
            alloc_gnt_vc_q <= '0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            occ_q          <= occ_d;
            rr_q           <= rr_d;
            alloc_gnt_q    <= alloc_gnt_d;
            alloc_gnt_vc_q <= alloc_gnt_vc_d;
            error_q        <= error_d;
        end
    end

    // Ownership map and occupancy flags decoded from registers
    always_comb begin
        allocated_ip_shared_ivc_o = '0;
        shared_ivc_empty_o        = '0;
        shared_ivc_full_o         = '0;
        for (int v = 0; v < NV; v++) begin
            shared_ivc_empty_o[v] = (occ_q[v] == ZERO_C);
            shared_ivc_full_o[v]  = (occ_q[v] == DEPTH_C);
            for (int p = 0; p < NP; p++) begin
                allocated_ip_shared_ivc_o[p*NV + v] = (state_q[v] == ST_ALLOC) &&
                                                      (owner_q[v] == PW'(p));
            end
        end
    end

    assign alloc_gnt_o    = alloc_gnt_q;
    assign alloc_gnt_vc_o = alloc_gnt_vc_q;
    assign error_o        = error_q;

endmodule
